// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM states and parameter helpers shared by the serial add sequencer
package serial_add_pkg;
  typedef enum logic [2:0] {IDLE, KICK, ISSUE, WAIT, DONE} state_t;
  function automatic int cnt_w(input int width);
    return width > 1 ? $clog2(width) : 1;
  endfunction
  function automatic bit bit_cyc_ok(input int add_lat, input int bit_cyc);
    return add_lat >= 1 && bit_cyc >= add_lat + 1;
  endfunction
endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: parallel-load right shift register, serial in at MSB, serial out is q[0]
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : load ? d : shift ? {sin, q[WIDTH-1:1]} : q;
endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: word-level handshake front/back end for a bit-serial full adder
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1,
  parameter int BIT_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             add_start,
  output logic             add_rst,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_s,
  input  logic             add_cout
);
  localparam int CNT_W  = cnt_w(WIDTH);
  localparam int WAIT_W = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WAIT_W-1:0] CNT_TOP  = WAIT_W'(BIT_CYC - 1);
  localparam logic [WAIT_W-1:0] SMP_CNT  = WAIT_W'(BIT_CYC - 1 - ADD_LAT);
  if (!bit_cyc_ok(ADD_LAT, BIT_CYC)) begin : g_bad_bit_cyc
    $error("serial_add_sequencer: BIT_CYC must be at least ADD_LAT+1");
  end
  state_t state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WAIT_W-1:0] cnt;
  logic carry, accept, issue, smp, unused;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  assign accept = state == IDLE && in_valid && in_ready;
  assign smp    = state == WAIT && cnt == SMP_CNT;
  assign issue  = state == ISSUE || (state == WAIT && cnt == '0 && bit_cnt != LAST_BIT);
  assign sum    = sum_q;
  assign cout   = carry;
  assign unused = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};
  serial_shift_reg #(.WIDTH(WIDTH)) u_a (
    .clk(CLK), .rst(RST), .load(accept), .shift(issue), .sin(1'b0), .d(op_a), .q(a_q)
  );
  serial_shift_reg #(.WIDTH(WIDTH)) u_b (
    .clk(CLK), .rst(RST), .load(accept), .shift(issue), .sin(1'b0), .d(op_b), .q(b_q)
  );
  serial_shift_reg #(.WIDTH(WIDTH)) u_sum (
    .clk(CLK), .rst(RST), .load(1'b0), .shift(smp), .sin(add_s), .d('0), .q(sum_q)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      add_start <= 1'b0;
      add_rst   <= 1'b1;
      add_a     <= 1'b0;
      add_b     <= 1'b0;
      add_cin   <= 1'b0;
      bit_cnt   <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
    end else begin
      if (smp) carry <= add_cout;
      if (issue) begin
        add_a   <= a_q[0];
        add_b   <= b_q[0];
        add_cin <= smp ? add_cout : carry;
        cnt     <= CNT_TOP;
      end
      case (state)
        IDLE: begin
          add_rst  <= 1'b0;
          in_ready <= !accept;
          if (accept) begin
            state     <= KICK;
            add_start <= 1'b1;
            carry     <= op_cin;
            bit_cnt   <= '0;
          end
        end
        KICK: begin
          add_start <= 1'b0;
          state     <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (bit_cnt == LAST_BIT) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else bit_cnt <= bit_cnt + 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            add_rst   <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed and random checks of the sequencer against a registered serial adder model
module tb_serial_add_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic op_cin = 1'b0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  int total = 0;
  int bad = 0;
  logic in_ready_0, out_valid_0, cout_0, add_start_0, add_rst_0, add_a_0, add_b_0, add_cin_0, add_s_0, add_cout_0;
  logic in_ready_1, out_valid_1, cout_1, add_start_1, add_rst_1, add_a_1, add_b_1, add_cin_1, add_s_1, add_cout_1;
  logic [7:0] sum_0, sum_1;
  logic in_ready, out_valid, cout, add_start, add_rst, add_cin;
  logic [7:0] sum;
  always #5 clk = ~clk;
  serial_add_sequencer #(.WIDTH(8), .ADD_LAT(1), .BIT_CYC(2)) u_dut2 (
    .CLK(clk), .RST(rst), .in_valid(in_valid & !sel), .in_ready(in_ready_0),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .out_valid(out_valid_0),
    .out_ready(out_ready & !sel), .sum(sum_0), .cout(cout_0), .add_start(add_start_0),
    .add_rst(add_rst_0), .add_a(add_a_0), .add_b(add_b_0), .add_cin(add_cin_0),
    .add_s(add_s_0), .add_cout(add_cout_0)
  );
  serial_add_sequencer #(.WIDTH(8), .ADD_LAT(1), .BIT_CYC(3)) u_dut3 (
    .CLK(clk), .RST(rst), .in_valid(in_valid & sel), .in_ready(in_ready_1),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .out_valid(out_valid_1),
    .out_ready(out_ready & sel), .sum(sum_1), .cout(cout_1), .add_start(add_start_1),
    .add_rst(add_rst_1), .add_a(add_a_1), .add_b(add_b_1), .add_cin(add_cin_1),
    .add_s(add_s_1), .add_cout(add_cout_1)
  );
  always_ff @(posedge clk) begin
    add_s_0    <= add_a_0 ^ add_b_0 ^ add_cin_0;
    add_cout_0 <= (add_a_0 & add_b_0) | (add_a_0 & add_cin_0) | (add_b_0 & add_cin_0);
    add_s_1    <= add_a_1 ^ add_b_1 ^ add_cin_1;
    add_cout_1 <= (add_a_1 & add_b_1) | (add_a_1 & add_cin_1) | (add_b_1 & add_cin_1);
  end
  assign in_ready  = sel ? in_ready_1  : in_ready_0;
  assign out_valid = sel ? out_valid_1 : out_valid_0;
  assign sum       = sel ? sum_1       : sum_0;
  assign cout      = sel ? cout_1      : cout_0;
  assign add_start = sel ? add_start_1 : add_start_0;
  assign add_rst   = sel ? add_rst_1   : add_rst_0;
  assign add_cin   = sel ? add_cin_1   : add_cin_0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic run_word(input logic [7:0] a, input logic [7:0] b, input logic c, input int bc,
                          output logic [8:0] res, output int lat, output int starts, output logic [7:0] cins);
    int n;
    op_a = a;
    op_b = b;
    op_cin = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n >= 50), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    starts = 0;
    cins = '0;
    while (!out_valid && lat < 100) begin
      starts += int'(add_start);
      if (lat >= 2 && (lat - 2) % bc == 0 && (lat - 2) / bc < 8) cins[(lat - 2) / bc] = add_cin;
      @(posedge clk); #1;
      lat++;
    end
    res = {cout, sum};
  endtask
  task automatic release_word();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [8:0] res, exp9;
    int lat, starts;
    logic [7:0] cins, ra, rb;
    logic rc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_add_rst", add_rst, 1);
    chk("rst_add_cin", add_cin, 0);
    rst = 1'b0;
    chk("post_rst_add_rst", add_rst, 1);
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_add_rst_clear", add_rst, 0);
    run_word(8'h00, 8'h00, 1'b0, 2, res, lat, starts, cins);
    chk("zero_res", res, 9'h000);
    chk("zero_latency", lat, 18);
    release_word();
    chk("zero_rel_out_valid", out_valid, 0);
    chk("zero_rel_in_ready", in_ready, 1);
    chk("zero_rel_add_rst", add_rst, 1);
    run_word(8'hFF, 8'h01, 1'b0, 2, res, lat, starts, cins);
    chk("ff01_res", res, 9'h100);
    chk("ff01_cin_bits", cins, 8'hFE);
    release_word();
    run_word(8'hA5, 8'h5A, 1'b1, 2, res, lat, starts, cins);
    chk("a55a_res", res, 9'h100);
    chk("a55a_start_pulses", starts, 1);
    chk("a55a_cin_bits", cins, 8'hFF);
    release_word();
    run_word(8'h1E, 8'h1E, 1'b0, 2, res, lat, starts, cins);
    chk("hold_res", res, 9'h03C);
    op_a = 8'h77;
    op_b = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_sum", sum, 8'h3C);
      chk("hold_cout", cout, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_word();
    chk("hold_rel_out_valid", out_valid, 0);
    chk("hold_rel_add_rst", add_rst, 1);
    chk("hold_rel_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("hold_add_rst_pulse_end", add_rst, 0);
    op_a = 8'hAB;
    op_b = 8'hCD;
    op_cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("midrst_in_ready_high", in_ready, 1);
    chk("midrst_out_valid_after", out_valid, 0);
    run_word(8'h12, 8'h34, 1'b0, 2, res, lat, starts, cins);
    chk("midrst_next_res", res, 9'h046);
    chk("midrst_next_latency", lat, 18);
    release_word();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(posedge clk); #1;
      for (int i = 0; i < 100; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        exp9 = 9'(ra) + 9'(rb) + 9'(rc);
        run_word(ra, rb, rc, 2 + s, res, lat, starts, cins);
        chk(s == 0 ? "rand_res_bc2" : "rand_res_bc3", res, exp9);
        chk(s == 0 ? "rand_lat_bc2" : "rand_lat_bc3", lat, 2 + 8 * (2 + s));
        release_word();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Word-level front/back end for the team's bit-serial full-adder stage. Accepts WIDTH-bit operand pairs over a valid/ready handshake and shifts them LSB-first into the serial adder. Each returned sum bit is captured into a result word, and COUT is fed back as CIN for the next bit. Presents the WIDTH-bit sum and final carry over a valid/ready output handshake.

Parameters:
WIDTH, 8, operand/result width in bits (2..32)
ADD_LAT, 1, cycles from driving add_a/add_b/add_cin to valid add_s/add_cout (registered adder outputs)
BIT_CYC, 2, cycles between successive bit issues; BIT_CYC >= ADD_LAT+1 is required and is checked by an elaboration assertion

Ports:
CLK  in  1  clock, all logic rising-edge
RST  in  1  synchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept operands
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
op_cin  in  1  carry-in for bit 0
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result word
cout  out  1  carry out of MSB
add_start  out  1  one-cycle start pulse to serial adder
add_rst  out  1  adder state clear
add_a  out  1  serial A bit
add_b  out  1  serial B bit
add_cin  out  1  serial carry-in
add_s  in  1  serial sum bit from adder
add_cout  in  1  serial carry from adder

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE; in_ready=0 during reset, 1 the cycle after.
  - out_valid=0, sum=0, cout=0.
  - add_start=0, add_a=add_b=add_cin=0, add_rst=1 for the reset cycle and the following cycle.
  - Reset mid-operation abandons the word; no partial result is ever presented.
- States: IDLE, KICK, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, load shift_a=op_a, shift_b=op_b, carry=op_cin, bit_cnt=0; go to KICK.
- KICK:
  - add_start=1 for exactly one cycle; go to ISSUE.
- ISSUE:
  - Drive add_a=shift_a[0], add_b=shift_b[0], add_cin=carry.
  - Load wait counter = BIT_CYC-1; go to WAIT.
  - add_a/add_b/add_cin hold their values until the next ISSUE.
- WAIT:
  - Decrement the counter.
  - On the cycle exactly ADD_LAT after ISSUE, sample add_s into sum_sr (shift right, MSB-in) and add_cout into carry.
  - At counter==0:
    - if bit_cnt==WIDTH-1, go to DONE;
    - else shift shift_a/shift_b right, bit_cnt+1, go to ISSUE.
- DONE:
  - out_valid=1; sum=sum_sr, cout=carry; both stable while out_valid=1 and out_ready=0.
  - On out_ready, assert add_rst one cycle and return to IDLE.
  - in_ready=0 here; no overlap between words.
- Throughput/latency: one word per 2 + WIDTH*BIT_CYC + 1 cycles minimum. First out_valid occurs 2 + WIDTH*BIT_CYC cycles after the accepting edge.
- Arithmetic: {cout,sum} == op_a + op_b + op_cin, modulo 2^(WIDTH+1).
- Boundary cases:
  - in_valid ignored outside IDLE.
  - out_ready ignored outside DONE.
  - add_s/add_cout ignored except on sample cycles.
  - bit_cnt is ceil(log2 WIDTH) bits wide; no wrap beyond WIDTH-1.

Decomposition:
- Package serial_add_pkg: state enum (IDLE, KICK, ISSUE, WAIT, DONE), localparam CNT_W = $clog2(WIDTH), BIT_CYC legality function.
- One natural sub-module: serial_shift_reg (parallel load, shift enable, serial in/out, parallel out), instantiated three times: A, B, sum.

Test Plan:
- op_a=8'h00, op_b=8'h00, op_cin=0 -> sum=8'h00, cout=0; out_valid exactly 2+8*2=18 cycles after accept.
- op_a=8'hFF, op_b=8'h01, op_cin=0 -> sum=8'h00, cout=1; add_cin observed =1 on bits 1..7.
- op_a=8'hA5, op_b=8'h5A, op_cin=1 -> sum=8'h00, cout=1; add_start pulses exactly once per word.
- Hold out_ready=0 for 10 cycles with sum=8'h3C -> sum/cout stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next cycle, add_rst pulse.
- RST asserted at bit 4 of a word -> out_valid stays 0, in_ready=1 two cycles later; the next word op_a=8'h12, op_b=8'h34, op_cin=0 -> sum=8'h46, cout=0.
- 200 random back-to-back words against a behavioural adder model (ADD_LAT=1, BIT_CYC=2 and BIT_CYC=3) -> every {cout,sum} matches op_a+op_b+op_cin.
